color_event_filter: RTL

//  Sits directly downstream of the colour sensor front end and consumes its 3-bit one-hot colour flags.

---
 rtl/color_pkg.sv | 35 +++
 rtl/color_event_filter_if.sv | 12 +
 rtl/sample_tick_gen.sv | 28 ++
 rtl/color_event_filter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
`default_nettype none
// color_pkg: colour codes, FSM state encodings and sensor flag decode helpers.
// Rev 1.0
package color_pkg;

   typedef enum logic [1:0] {
      COLOR_NONE  = 2'd0,
      COLOR_RED   = 2'd1,
      COLOR_BLUE  = 2'd2,
      COLOR_GREEN = 2'd3
   } color_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONFIRM = 2'd1,
      S_REPORT  = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   // Multi-hot flags decode to NONE; the caller flags them separately.
   function automatic color_t decode_flags(input logic [2:0] flags);
      case (flags)
         3'b001:  return COLOR_RED;
         3'b010:  return COLOR_BLUE;
         3'b100:  return COLOR_GREEN;
         default: return COLOR_NONE;
      endcase
   endfunction

   function automatic logic is_multi_hot(input logic [2:0] flags);
      return (flags & (flags - 3'd1)) != 3'b000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/color_event_filter_if.sv
`default_nettype none
// color_event_filter_if: valid/ready detection event channel.
// Rev 1.0
interface color_event_filter_if;
   logic       det_valid;
   logic       det_ready;
   logic [1:0] det_color;

   modport master (output det_valid, output det_color, input det_ready);
   modport slave  (input det_valid, input det_color, output det_ready);
endinterface
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// sample_tick_gen: free-running divider, tick high on the last count of each DIV-cycle period.
// Rev 1.0
module sample_tick_gen #(
   parameter int DIV = 100000
) (
   input  wire logic clk,
   input  wire logic rst_n,
   output logic      tick
);
   localparam int              W    = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]    LAST = W'(DIV - 1);

   logic [W-1:0] div_cnt;

   assign tick = (div_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/color_event_filter.sv
`default_nettype none
// color_event_filter: debounces one-hot colour flags into one valid/ready event per object.
// Rev 1.0. Optional per-colour saturating tallies when COLOR_TALLY_EN is defined.
module color_event_filter
   import color_pkg::*;
#(
   parameter int SAMPLE_DIV = 100000,
   parameter int CONFIRM_N  = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic [2:0]       color_in,
   color_event_filter_if.master  det,
`ifdef COLOR_TALLY_EN
   output logic [7:0]            tally_red,
   output logic [7:0]            tally_blue,
   output logic [7:0]            tally_green,
`endif
   output logic                  invalid_seen
);
   localparam logic [3:0] C_CONFIRM_N = 4'(CONFIRM_N);

   logic       tick;
   color_t     code;
   logic       handshake;
   state_t     state, state_n;
   logic [3:0] match_cnt, match_n;
   logic [3:0] match_inc;
   color_t     cand, cand_n;

   sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign code      = decode_flags(color_in);
   assign handshake = det.det_valid & det.det_ready;
   assign match_inc = match_cnt + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         match_cnt <= '0;
         cand      <= COLOR_NONE;
      end else begin
         state     <= state_n;
         match_cnt <= match_n;
         cand      <= cand_n;
      end
   end

   always_comb begin
      state_n = state;
      match_n = match_cnt;
      cand_n  = cand;
      case (state)
         S_IDLE: begin
            if (tick && code != COLOR_NONE) begin
               cand_n  = code;
               match_n = 4'd1;
               state_n = (CONFIRM_N == 1) ? S_REPORT : S_CONFIRM;
            end
         end
         S_CONFIRM: begin
            if (tick) begin
               if (code == COLOR_NONE) begin
                  state_n = S_IDLE;
                  match_n = '0;
               end else if (code == cand) begin
                  match_n = match_inc;
                  if (match_inc == C_CONFIRM_N) state_n = S_REPORT;
               end else begin
                  cand_n  = code;
                  match_n = 4'd1;
               end
            end
         end
         // Acceptance is not tied to the tick; any clock cycle completes the handshake.
         S_REPORT: begin
            if (handshake) begin
               state_n = S_HOLD;
               match_n = '0;
            end
         end
         S_HOLD: begin
            if (tick) begin
               if (code == COLOR_NONE) begin
                  match_n = match_inc;
                  if (match_inc == C_CONFIRM_N) begin
                     state_n = S_IDLE;
                     match_n = '0;
                  end
               end else begin
                  match_n = '0;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
            match_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         det.det_valid <= 1'b0;
         det.det_color <= 2'd0;
         invalid_seen  <= 1'b0;
      end else begin
         det.det_valid <= (state_n == S_REPORT);
         if (state_n == S_REPORT) det.det_color <= cand_n;
         if (tick && is_multi_hot(color_in)) invalid_seen <= 1'b1;
      end
   end

`ifdef COLOR_TALLY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tally_red   <= '0;
         tally_blue  <= '0;
         tally_green <= '0;
      end else if (handshake) begin
         case (det.det_color)
            2'd1:    if (tally_red   != 8'hFF) tally_red   <= tally_red   + 8'd1;
            2'd2:    if (tally_blue  != 8'hFF) tally_blue  <= tally_blue  + 8'd1;
            2'd3:    if (tally_green != 8'hFF) tally_green <= tally_green + 8'd1;
            default: ;
         endcase
      end
   end
`endif

endmodule
`default_nettype wire
